instr_fetch: RTL and testbench

//  Fetch stage ahead of the main decoder. Owns the PC and issues in-order word requests to instruction memory.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/instr_fetch_if.sv | 39 +++
 rtl/fetch_fifo.sv | 81 ++++++++
 rtl/instr_fetch.sv | 167 ++++++++++++++++
 tb/tb_instr_fetch.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Shared definitions for the fetch slice: default datapath width and reset
//   vector, the major opcodes that decode keys on, and the fetch FSM states.
//   No ports; imported by instr_fetch_if, fetch_fifo and instr_fetch.
package riscv_pkg;

    localparam int unsigned     XLEN      = 32;
    localparam logic [31:0]     RESET_VEC = 32'h0000_0000;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if
//   Bundles the instruction-memory request/response channel and the
//   fetch-to-decode valid/ready channel.
//   master : fetch side (drives imem request, drives decode outputs)
//   slave  : environment side (memory + decoder)
//   imem_req_valid/ready/addr   word request to instruction memory
//   imem_rsp_valid/data         in-order response words
//   if_valid/ready              decode handshake
//   if_instr/if_opcode/if_pc    instruction presented to decode
interface instr_fetch_if
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = riscv_pkg::XLEN
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [6:0]      if_opcode;
    logic [XLEN-1:0] if_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output if_valid, if_instr, if_opcode, if_pc,
        input  if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  if_valid, if_instr, if_opcode, if_pc,
        output if_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo
//   Synchronous FIFO, DEPTH x WIDTH, DEPTH a power of two >= 2.
//   clk, rst_n   clock, asynchronous active-low reset
//   push/data    write an entry (ignored when full unless popping)
//   pop          remove the head entry (ignored when empty)
//   flush        empty the FIFO; wins over push and pop
//   rd_data      head entry, zero while empty
//   count/full/empty  occupancy
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        full    = (count_q == CW'(DEPTH));
        empty   = (count_q == '0);
        count   = count_q;
        rd_data = empty ? '0 : mem_q[rd_ptr_q];
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            do_pop  = pop && !empty;
            do_push = push && (!full || do_pop);
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch
//   Fetch stage: owns the PC, issues in-order word requests to instruction
//   memory, buffers returned words with their PC and presents them to decode.
//   Redirects flush the buffer and discard wrong-path words still in flight.
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (master)      imem request/response and decode handshake
//   redirect_valid/pc single-cycle redirect from execute
//   perf_fetched      instructions handed to decode
//   perf_stall        cycles with if_ready && !if_valid
//   Define FETCH_PERF_CNT_EN to build the performance counters; otherwise
//   both perf ports are tied to zero.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN       = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VEC  = riscv_pkg::RESET_VEC,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    instr_fetch_if.master     bus,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
);
    localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   live_cnt_q, live_cnt_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    logic [CW-1:0]        fifo_cnt;
    logic                 fifo_full, fifo_empty;
    logic                 fifo_push, fifo_pop;
    logic [XLEN+31:0]     fifo_wdata, fifo_rdata;

    logic            req_valid, req_fire, rsp_live, rsp_drop;
    logic [CW:0]     live_drop_sum, live_fifo_sum;
    logic [XLEN-1:0] redirect_pc_al;

    always_comb begin
        redirect_pc_al = redirect_pc & ~XLEN'(3);
        live_drop_sum  = {1'b0, live_cnt_q} + {1'b0, drop_cnt_q};
        live_fifo_sum  = {1'b0, live_cnt_q} + {1'b0, fifo_cnt};
        req_valid      = (state_q != BOOT) && !redirect_valid &&
                         (live_drop_sum < DEPTH_L) && (live_fifo_sum < DEPTH_L);
        req_fire       = req_valid && bus.imem_req_ready;
        rsp_drop       = bus.imem_rsp_valid && (drop_cnt_q != '0);
        rsp_live       = bus.imem_rsp_valid && (drop_cnt_q == '0);
    end

    // Live responses return in request order and request PCs are sequential
    // between redirects, so a single running PC (rsp_pc) tags each live word
    // instead of a per-request tag queue.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        live_cnt_d = live_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            pc_d       = redirect_pc_al;
            rsp_pc_d   = redirect_pc_al;
            live_cnt_d = '0;
            // A response arriving now is wrong-path and retires one outstanding slot.
            drop_cnt_d = drop_cnt_q + live_cnt_q - CW'(bus.imem_rsp_valid);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + XLEN'(4);
            end
            if (rsp_live) begin
                rsp_pc_d = rsp_pc_q + XLEN'(4);
            end
            live_cnt_d = live_cnt_q + CW'(req_fire) - CW'(rsp_live);
            drop_cnt_d = drop_cnt_q - CW'(rsp_drop);
        end

        case (state_q)
            BOOT:    state_d = FETCH;
            FETCH:   if (redirect_valid && (drop_cnt_d != '0)) state_d = FLUSH;
            FLUSH:   if (drop_cnt_d == '0) state_d = FETCH;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VEC;
            rsp_pc_q   <= RESET_VEC;
            live_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            live_cnt_q <= live_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        fifo_push  = rsp_live && !redirect_valid;
        fifo_pop   = !fifo_empty && bus.if_ready && !redirect_valid;
        fifo_wdata = {rsp_pc_q, bus.imem_rsp_data};
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (XLEN + 32)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .rd_data   (fifo_rdata),
        .count     (fifo_cnt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        bus.imem_req_valid = req_valid;
        bus.imem_req_addr  = pc_q;
        bus.if_valid       = !fifo_empty;
        bus.if_pc          = fifo_rdata[XLEN+31:32];
        bus.if_instr       = fifo_rdata[31:0];
        bus.if_opcode      = fifo_rdata[6:0];
    end

    // The credit rule leaves room for every outstanding word.
    a_no_rsp_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.imem_rsp_valid && fifo_full));

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(fifo_pop);
        perf_stall_d   = perf_stall_q + 32'(bus.if_ready && fifo_empty);
        perf_fetched   = perf_fetched_q;
        perf_stall     = perf_stall_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end
`else
    always_comb begin
        perf_fetched = '0;
        perf_stall   = '0;
    end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch
//   Directed self-checking bench for instr_fetch with a latency-programmable
//   in-order instruction memory model.
module tb_instr_fetch;
    import riscv_pkg::*;

    localparam int unsigned XLEN = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] perf_fetched, perf_stall;

    instr_fetch_if #(.XLEN(XLEN)) bus ();

    instr_fetch #(
        .XLEN       (XLEN),
        .RESET_VEC  (32'h0),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
    );

    always #5 clk = ~clk;

    int tests;
    int fails;
    int cyc;
    int lat;
    int fire_cnt;
    int pops;
    int stalls;
    logic [31:0] addr_log [$];
    logic [31:0] pend_addr [$];
    int          pend_due [$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [6:0] op;
        case (a[3:2])
            2'd0:    op = OP_LOAD;
            2'd1:    op = OP_STORE;
            2'd2:    op = OP_RTYPE;
            default: op = OP_BRANCH;
        endcase
        return {a[26:2], op};
    endfunction

    // Memory model: response driven at posedge+1, request capture at posedge+9.
    initial begin
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        cyc      = 0;
        fire_cnt = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!rst_n) begin
                pend_addr.delete();
                pend_due.delete();
                bus.imem_rsp_valid = 1'b0;
            end else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = word_of(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                bus.imem_rsp_valid = 1'b0;
            end
            #8;
            if (rst_n && bus.imem_req_valid && bus.imem_req_ready) begin
                fire_cnt++;
                addr_log.push_back(bus.imem_req_addr);
                if (lat == 0) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = word_of(bus.imem_req_addr);
                end else begin
                    pend_addr.push_back(bus.imem_req_addr);
                    pend_due.push_back(cyc + lat);
                end
            end
        end
    end

    // Reference pop/stall counts for the optional perf counters.
    always @(negedge clk) begin
        if (!rst_n) begin
            pops   <= 0;
            stalls <= 0;
        end else begin
            if (bus.if_valid && bus.if_ready && !redirect_valid) pops <= pops + 1;
            if (bus.if_ready && !bus.if_valid) stalls <= stalls + 1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_perf(input string tag, input int exp_f, input int exp_s);
`ifdef FETCH_PERF_CNT_EN
        chk({tag, "_perf_fetched"}, 64'(perf_fetched), 64'(exp_f));
        chk({tag, "_perf_stall"},   64'(perf_stall),   64'(exp_s));
`else
        chk({tag, "_perf_fetched_tied"}, 64'(perf_fetched), 64'(0));
        chk({tag, "_perf_stall_tied"},   64'(perf_stall),   64'(0));
`endif
    endtask

    // Waits (bounded) for the next word handed to decode; if_ready must be 1.
    task automatic expect_pc(input string tag, input logic [31:0] pc);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.if_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"},  64'(bus.if_valid),  64'(1));
        chk({tag, "_pc"},     64'(bus.if_pc),     64'(pc));
        chk({tag, "_instr"},  64'(bus.if_instr),  64'(word_of(pc)));
        chk({tag, "_opcode"}, 64'(bus.if_opcode), 64'(word_of(pc) & 32'h7f));
    endtask

    task automatic do_reset(input int l, input logic rdy);
        @(posedge clk);
        #2;
        rst_n          = 1'b0;
        lat            = l;
        bus.if_ready   = rdy;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic wait_fires(input int base, input int n);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            if (fire_cnt - base == n) break;
        end
    endtask

    int base;
    int logn;
    logic [31:0] a0, a1;

    initial begin
        tests          = 0;
        fails          = 0;
        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        bus.if_ready   = 1'b1;
        lat            = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_valid", 64'(bus.imem_req_valid), 64'(0));
        chk("rst_req_addr",  64'(bus.imem_req_addr),  64'(32'h0));
        chk("rst_if_valid",  64'(bus.if_valid),       64'(0));
        chk("rst_if_instr",  64'(bus.if_instr),       64'(0));
        chk("rst_if_pc",     64'(bus.if_pc),          64'(0));
        chk("rst_if_opcode", 64'(bus.if_opcode),      64'(0));
        chk_perf("rst", 0, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // 1: zero-latency memory, one instruction per cycle
        @(negedge clk);
        chk("t1_boot_noreq", 64'(bus.imem_req_valid), 64'(0));
        @(negedge clk);
        chk("t1_first_req",  64'(bus.imem_req_valid), 64'(1));
        chk("t1_first_addr", 64'(bus.imem_req_addr),  64'(32'h0));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("t1_valid%0d", k), 64'(bus.if_valid), 64'(1));
            chk($sformatf("t1_pc%0d", k),    64'(bus.if_pc),    64'(4 * k));
            chk($sformatf("t1_op%0d", k),    64'(bus.if_opcode), 64'(word_of(32'(4 * k)) & 32'h7f));
        end
        @(posedge clk);
        #2;
        chk_perf("t1", pops, stalls);

        // 2: decode stalled, buffer fills and issue stops
        do_reset(1, 1'b0);
        base = fire_cnt;
        repeat (10) @(negedge clk);
        chk("t2_reqs",      64'(fire_cnt - base),     64'(2));
        chk("t2_noreq",     64'(bus.imem_req_valid),  64'(0));
        chk("t2_full_valid", 64'(bus.if_valid),       64'(1));
        chk("t2_head_pc",   64'(bus.if_pc),           64'(0));
        @(posedge clk);
        #2 bus.if_ready = 1'b1;
        for (int k = 0; k < 5; k++) expect_pc($sformatf("t2_w%0d", k), 32'(4 * k));

        // 3: redirect with two requests in flight, 3-cycle memory
        do_reset(3, 1'b1);
        base = fire_cnt;
        wait_fires(base, 2);
        chk("t3_inflight", 64'(fire_cnt - base), 64'(2));
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0105;
        logn           = addr_log.size();
        @(negedge clk);
        chk("t3_redir_noreq", 64'(bus.imem_req_valid), 64'(0));
        @(posedge clk);
        #2 redirect_valid = 1'b0;
        expect_pc("t3_w0", 32'h104);
        expect_pc("t3_w1", 32'h108);
        a0 = (addr_log.size() > logn) ? addr_log[logn] : 32'hxxxx_xxxx;
        chk("t3_new_addr", 64'(a0), 64'(32'h104));

        // 4: redirect coinciding with a response and a pop
        do_reset(1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            if (bus.imem_rsp_valid && bus.if_valid) break;
        end
        chk("t4_setup", 64'(bus.imem_rsp_valid && bus.if_valid), 64'(1));
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        @(posedge clk);
        #2 redirect_valid = 1'b0;
        @(negedge clk);
        chk("t4_empty", 64'(bus.if_valid), 64'(0));
        expect_pc("t4_w0", 32'h200);
        expect_pc("t4_w1", 32'h204);

        // 5: PC wraps past the top of the address space
        @(posedge clk);
        #2;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        logn           = addr_log.size();
        @(posedge clk);
        #2 redirect_valid = 1'b0;
        expect_pc("t5_w0", 32'hFFFF_FFFC);
        expect_pc("t5_w1", 32'h0000_0000);
        expect_pc("t5_w2", 32'h0000_0004);
        a0 = (addr_log.size() > logn)     ? addr_log[logn]     : 32'hxxxx_xxxx;
        a1 = (addr_log.size() > logn + 1) ? addr_log[logn + 1] : 32'hxxxx_xxxx;
        chk("t5_addr0", 64'(a0), 64'(32'hFFFF_FFFC));
        chk("t5_addr1", 64'(a1), 64'(32'h0000_0000));

        // 6: reset asserted while flushing
        do_reset(3, 1'b1);
        base = fire_cnt;
        wait_fires(base, 2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
        rst_n          = 1'b0;
        #1;
        chk("t6_if_valid",  64'(bus.if_valid),       64'(0));
        chk("t6_req_valid", 64'(bus.imem_req_valid), 64'(0));
        chk("t6_req_addr",  64'(bus.imem_req_addr),  64'(32'h0));
        chk_perf("t6_rst", 0, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        chk_perf("t6_rel", 0, 0);
        @(negedge clk);
        chk("t6_boot_noreq", 64'(bus.imem_req_valid), 64'(0));
        @(negedge clk);
        chk("t6_req",  64'(bus.imem_req_valid), 64'(1));
        chk("t6_addr", 64'(bus.imem_req_addr),  64'(32'h0));
        expect_pc("t6_w0", 32'h0);
        expect_pc("t6_w1", 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
